flick_conditioner: RTL and testbench
====================================

Name: flick_conditioner

Overview:
- Upstream front end for bound_flasher.
- Takes the raw, asynchronous, possibly bouncing flick button and synchronises it into clk. Debounces it with a confirm-counter FSM.
- Produces a clean level (flick), a one-cycle press pulse (flick_pulse, fed to bound_flasher's flick input) and a one-shot long-press indication (flick_long).

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on flick_raw; must be ≥2.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to accept a level change; must be ≥2.
- LONG_PRESS_CYCLES, 8, cycles flick must stay high before flick_long fires; must be ≥1.
- CNT_W, 8, width of the debounce and hold counters; must hold max(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES).

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst_n, input, 1, reset; asynchronous, active-low.
- flick_raw, input, 1, raw button, asynchronous to clk, active-high.
- flick, output, 1, debounced level, registered.
- flick_pulse, output, 1, one-cycle pulse on accepted press, registered.
- flick_long, output, 1, one-cycle pulse when a press has lasted LONG_PRESS_CYCLES, registered.

Behaviour:
- Reset (rst_n=0, asynchronous): all synchroniser flops 0, state IDLE, counters 0, flick=0, flick_pulse=0, flick_long=0.
- Outputs clear immediately, without waiting for a clock edge.
- sync_out is the last synchroniser stage. The FSM only ever looks at sync_out.
- FSM states: IDLE, CONFIRM_HI, PRESSED, CONFIRM_LO.
- IDLE (flick=0):
  - sync_out=1 → CONFIRM_HI, cnt=1.
- CONFIRM_HI (flick=0):
  - sync_out=0 → IDLE, cnt=0.
  - sync_out=1 and cnt==DEBOUNCE_CYCLES-1 → PRESSED; flick=1; flick_pulse=1 for exactly this one cycle; hold=0; long_done=0.
  - Otherwise cnt+1.
- PRESSED (flick=1):
  - hold increments each cycle, saturating at LONG_PRESS_CYCLES.
  - When hold becomes LONG_PRESS_CYCLES with long_done=0: flick_long=1 for one cycle, long_done=1.
  - sync_out=0 → CONFIRM_LO, cnt=1.
- CONFIRM_LO (flick stays 1; hold keeps counting and flick_long can still fire):
  - sync_out=1 → PRESSED (bounce). hold and long_done are retained; no new flick_pulse.
  - sync_out=0 and cnt==DEBOUNCE_CYCLES-1 → IDLE; flick=0.
  - Otherwise cnt+1.
- Latency:
  - Counting the first rising edge that samples flick_raw high as edge 1, flick and flick_pulse go high after edge SYNC_STAGES+DEBOUNCE_CYCLES. With defaults this is edge 6.
  - Release is symmetric: flick falls after edge SYNC_STAGES+DEBOUNCE_CYCLES counting from the first edge that samples flick_raw low.
  - flick_long goes high after the LONG_PRESS_CYCLES-th edge following the edge that raised flick.
- Glitch rejection: any high or low excursion shorter than DEBOUNCE_CYCLES synchronised samples produces no output change.
- Pulse counts:
  - At most one flick_pulse per accepted press.
  - At most one flick_long per accepted press.
  - flick_pulse and flick_long never high in the same cycle (LONG_PRESS_CYCLES ≥1).
- Held through reset: flick_raw held high across rst_n deassertion is treated as a new press and pulses after the normal latency. No pulse is issued while rst_n=0.
- Counter safety: counters never wrap; hold saturates.

Test Plan:
- Reset with flick_raw=1, release rst_n → all outputs 0 while rst_n=0; flick_pulse single cycle after edge 6 post-release (SYNC_STAGES=2, DEBOUNCE_CYCLES=4); flick=1.
- Clean 5-cycle press (flick_raw high 5 edges, then low) → flick_pulse high after edge 6 only. flick high from edge 6 until edge 6 after release. flick_long never asserts.
- Glitches of 1, 2 and 3 cycles high while idle, and 3 cycles low while pressed → no change on flick, no flick_pulse, no flick_long.
- Release bounce: during press drop flick_raw low 2 cycles then high again, then hold → flick stays 1 throughout, no second flick_pulse. Final clean release drops flick after the normal latency.
- 20-cycle press (LONG_PRESS_CYCLES=8) → exactly one flick_long, high after the 8th edge following flick rise. No repeat while still held.
- rst_n pulled low mid-PRESSED between clock edges → flick, flick_pulse and flick_long go 0 without a clock edge. After rst_n=1 with flick_raw still high, exactly one new flick_pulse after edge 6.

Source files
------------

// File: rtl/flick_conditioner.sv
// Purpose: synchronise and debounce the raw flick button into a clean level, a press pulse and a long-press pulse.
// Latency: flick/flick_pulse follow a clean edge on flick_raw by SYNC_STAGES+DEBOUNCE_CYCLES clocks; flick_long follows flick rise by LONG_PRESS_CYCLES.
// Backpressure: none; outputs are free-running single-cycle pulses with no handshake.
//
// Ports:
//   clk         - system clock, all logic on rising edge
//   rst_n       - asynchronous active-low reset
//   flick_raw   - raw, bouncing, asynchronous button input (active high)
//   flick       - debounced level (registered)
//   flick_pulse - one-cycle pulse on each accepted press (registered)
//   flick_long  - one-cycle pulse once a press has lasted LONG_PRESS_CYCLES (registered)
module flick_conditioner #(
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned DEBOUNCE_CYCLES   = 4,
    parameter int unsigned LONG_PRESS_CYCLES = 8,
    parameter int unsigned CNT_W             = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flick_raw,
    output logic flick,
    output logic flick_pulse,
    output logic flick_long
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CONFIRM_HI = 2'd1,
        PRESSED    = 2'd2,
        CONFIRM_LO = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_PRESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       hold;
    logic [CNT_W-1:0]       hold_inc;
    logic                   long_done;

    // Synchroniser chain; only the last stage is ever observed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], flick_raw};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Saturating hold count: never wraps, so long press cannot re-fire on overflow.
    assign hold_inc = (hold == LONG_MAX) ? hold : hold + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            hold        <= '0;
            long_done   <= 1'b0;
            flick       <= 1'b0;
            flick_pulse <= 1'b0;
            flick_long  <= 1'b0;
        end else begin
            flick_pulse <= 1'b0;
            flick_long  <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_out) begin
                        state <= CONFIRM_HI;
                        cnt   <= CNT_ONE;
                    end
                end
                CONFIRM_HI: begin
                    if (!sync_out) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state       <= PRESSED;
                        cnt         <= '0;
                        flick       <= 1'b1;
                        flick_pulse <= 1'b1;
                        hold        <= '0;
                        long_done   <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    hold <= hold_inc;
                    if (hold_inc == LONG_MAX && !long_done) begin
                        flick_long <= 1'b1;
                        long_done  <= 1'b1;
                    end
                    if (!sync_out) begin
                        state <= CONFIRM_LO;
                        cnt   <= CNT_ONE;
                    end
                end
                CONFIRM_LO: begin
                    // Press is still live while confirming release, so the
                    // long-press timer keeps running and may still fire here.
                    hold <= hold_inc;
                    if (hold_inc == LONG_MAX && !long_done) begin
                        flick_long <= 1'b1;
                        long_done  <= 1'b1;
                    end
                    if (sync_out) begin
                        // Release bounce: resume the same press, no new pulse.
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        flick <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flick_conditioner.sv
// Purpose: self-checking bench for flick_conditioner against a streak-counting reference model.
// Latency: model predicts outputs per clock edge; outputs sampled 1ns after each rising edge.
// Backpressure: not applicable.
module tb_flick_conditioner;

    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int LONGP = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flick_raw = 1'b0;
    logic flick;
    logic flick_pulse;
    logic flick_long;

    flick_conditioner #(
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_PRESS_CYCLES(LONGP),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flick_raw(flick_raw),
        .flick(flick),
        .flick_pulse(flick_pulse),
        .flick_long(flick_long)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int base = 0;
    int npulse, nlong, pulse_at, long_at;

    // Reference model: delay line of raw samples, a streak counter of samples
    // disagreeing with the accepted level, and the age of the current press.
    bit hist[$];
    bit m_flick, m_pulse, m_long;
    int m_run, m_age;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
        m_flick = 1'b0;
        m_pulse = 1'b0;
        m_long  = 1'b0;
        m_run   = 0;
        m_age   = 0;
    endtask

    task automatic model_edge(input bit raw);
        bit s;
        if (!rst_n) begin
            model_reset();
            return;
        end
        s = hist.pop_front();
        hist.push_back(raw);
        m_pulse = 1'b0;
        m_long  = 1'b0;
        if (m_flick) begin
            m_age++;
            m_long = (m_age == LONGP);
        end
        if (s != m_flick) m_run++;
        else m_run = 0;
        if (m_run == DEB) begin
            m_flick = !m_flick;
            m_run = 0;
            if (m_flick) begin
                m_pulse = 1'b1;
                m_age = 0;
            end
        end
    endtask

    task automatic step(input bit raw);
        flick_raw = raw;
        @(posedge clk);
        model_edge(raw);
        cyc++;
        #1;
        check("flick", flick, m_flick);
        check("flick_pulse", flick_pulse, m_pulse);
        check("flick_long", flick_long, m_long);
        if (flick_pulse) begin
            npulse++;
            pulse_at = cyc;
        end
        if (flick_long) begin
            nlong++;
            long_at = cyc;
        end
    endtask

    task automatic run(input bit raw, input int n);
        repeat (n) step(raw);
    endtask

    task automatic begin_scn();
        npulse = 0;
        nlong = 0;
        pulse_at = -1;
        long_at = -1;
        base = cyc;
    endtask

    initial begin
        bit lvl;
        int len;

        // Reset held with button pressed: nothing may come out.
        rst_n = 1'b0;
        flick_raw = 1'b1;
        model_reset();
        #2;
        check("reset_flick", flick, 0);
        check("reset_pulse", flick_pulse, 0);
        check("reset_long", flick_long, 0);
        begin_scn();
        run(1'b1, 3);
        check("reset_no_pulse", npulse, 0);

        // Release reset with button still held: one press after normal latency.
        begin_scn();
        rst_n = 1'b1;
        run(1'b1, 12);
        check("rsthold_pulses", npulse, 1);
        check("rsthold_latency", pulse_at - base, SYNC + DEB);
        check("rsthold_level", flick, 1);
        run(1'b0, 12);

        // Clean 5-cycle press.
        begin_scn();
        run(1'b1, 5);
        run(1'b0, 12);
        check("clean_pulses", npulse, 1);
        check("clean_latency", pulse_at - base, SYNC + DEB);
        check("clean_long", nlong, 0);
        check("clean_released", flick, 0);

        // Short high glitches while idle.
        for (int w = 1; w <= 3; w++) begin
            begin_scn();
            run(1'b1, w);
            run(1'b0, 8);
            check("glitch_hi_pulses", npulse, 0);
            check("glitch_hi_level", flick, 0);
        end

        // Short low glitch while pressed.
        run(1'b1, 8);
        begin_scn();
        run(1'b0, 3);
        run(1'b1, 4);
        check("glitch_lo_pulses", npulse, 0);
        check("glitch_lo_level", flick, 1);
        run(1'b0, 12);

        // Release bounce then final clean release.
        begin_scn();
        run(1'b1, 10);
        run(1'b0, 2);
        run(1'b1, 10);
        run(1'b0, 12);
        check("bounce_pulses", npulse, 1);
        check("bounce_long", nlong, 1);
        check("bounce_released", flick, 0);

        // Long 20-cycle press.
        begin_scn();
        run(1'b1, 20);
        run(1'b0, 12);
        check("long_pulses", npulse, 1);
        check("long_count", nlong, 1);
        check("long_delay", long_at - pulse_at, LONGP);

        // Asynchronous reset in the middle of a press.
        run(1'b1, 10);
        check("midrst_pressed", flick, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_flick", flick, 0);
        check("midrst_pulse", flick_pulse, 0);
        check("midrst_long", flick_long, 0);
        model_reset();
        run(1'b1, 3);
        rst_n = 1'b1;
        begin_scn();
        run(1'b1, 10);
        check("midrst_repress", npulse, 1);
        check("midrst_latency", pulse_at - base, SYNC + DEB);
        run(1'b0, 12);

        // Random run lengths, mixing glitches, presses and long holds.
        repeat (300) begin
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 12));
            run(lvl, len);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
